seg7_stream_decoder: RTL and testbench

//  Receive-side counterpart of the 7-segment digit driver: samples an active-low

---
 rtl/seg7_stream_decoder.sv | 136 +++++++++++++
 tb/tb_seg7_stream_decoder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_stream_decoder.sv
// Decodes a glitch-filtered, active-low 7-segment bus back to BCD digits,
// checks that digits count up modulo 10, and counts protocol errors.
module seg7_stream_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_n,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             blank,
  output logic             invalid,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {IDLE, TRACK} state_t;

  localparam logic [15:0] STAB_MAX  = 16'(STABLE_CYCLES - 1);
  localparam logic [6:0]  PAT_BLANK = 7'h7F;

  state_t           state_reg, state_next;
  logic [6:0]       cand_reg, cand_next;
  logic [15:0]      stab_cnt_reg, stab_cnt_next;
  logic [6:0]       last_pat_reg, last_pat_next;
  logic [3:0]       digit_reg, digit_next;
  logic             digit_valid_reg, digit_valid_next;
  logic             blank_reg, blank_next;
  logic             invalid_reg, invalid_next;
  logic             seq_err_reg, seq_err_next;
  logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;

  logic             accept;
  logic             pat_is_digit;
  logic [3:0]       pat_digit;
  logic [3:0]       expected_digit;

  always_comb begin
    pat_is_digit = 1'b1;
    pat_digit    = 4'd0;
    case (seg_n)
      7'h40:   pat_digit = 4'd0;
      7'h79:   pat_digit = 4'd1;
      7'h24:   pat_digit = 4'd2;
      7'h30:   pat_digit = 4'd3;
      7'h19:   pat_digit = 4'd4;
      7'h12:   pat_digit = 4'd5;
      7'h02:   pat_digit = 4'd6;
      7'h78:   pat_digit = 4'd7;
      7'h00:   pat_digit = 4'd8;
      7'h10:   pat_digit = 4'd9;
      default: pat_is_digit = 1'b0;
    endcase
  end

  always_comb begin
    cand_next     = seg_n;
    stab_cnt_next = stab_cnt_reg;
    if (seg_n != cand_reg) begin
      stab_cnt_next = 16'd0;
    end else if (stab_cnt_reg < STAB_MAX) begin
      stab_cnt_next = stab_cnt_reg + 16'd1;
    end
    // Judged on the updated count so the pulse lands on the last required sample.
    accept = (stab_cnt_next == STAB_MAX) && (seg_n != last_pat_reg);
  end

  assign expected_digit = (digit_reg == 4'd9) ? 4'd0 : digit_reg + 4'd1;

  always_comb begin
    state_next       = state_reg;
    last_pat_next    = last_pat_reg;
    digit_next       = digit_reg;
    digit_valid_next = 1'b0;
    blank_next       = blank_reg;
    invalid_next     = 1'b0;
    seq_err_next     = 1'b0;
    err_cnt_next     = err_cnt_reg;
    if (accept) begin
      last_pat_next = seg_n;
      if (pat_is_digit) begin
        digit_next       = pat_digit;
        digit_valid_next = 1'b1;
        blank_next       = 1'b0;
        state_next       = TRACK;
        if (state_reg == TRACK && pat_digit != expected_digit) begin
          seq_err_next = 1'b1;
        end
      end else if (seg_n == PAT_BLANK) begin
        blank_next = 1'b1;
        state_next = IDLE;
      end else begin
        invalid_next = 1'b1;
        state_next   = IDLE;
      end
    end
    if ((invalid_next || seq_err_next) && err_cnt_reg != {ERR_W{1'b1}}) begin
      err_cnt_next = err_cnt_reg + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cand_reg        <= PAT_BLANK;
      stab_cnt_reg    <= 16'd0;
      last_pat_reg    <= PAT_BLANK;
      digit_reg       <= 4'd0;
      digit_valid_reg <= 1'b0;
      blank_reg       <= 1'b1;
      invalid_reg     <= 1'b0;
      seq_err_reg     <= 1'b0;
      err_cnt_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      cand_reg        <= cand_next;
      stab_cnt_reg    <= stab_cnt_next;
      last_pat_reg    <= last_pat_next;
      digit_reg       <= digit_next;
      digit_valid_reg <= digit_valid_next;
      blank_reg       <= blank_next;
      invalid_reg     <= invalid_next;
      seq_err_reg     <= seq_err_next;
      err_cnt_reg     <= err_cnt_next;
    end
  end

  assign digit       = digit_reg;
  assign digit_valid = digit_valid_reg;
  assign blank       = blank_reg;
  assign invalid     = invalid_reg;
  assign seq_err     = seq_err_reg;
  assign err_cnt     = err_cnt_reg;

endmodule

// File: tb/tb_seg7_stream_decoder.sv
// Scoreboard bench for seg7_stream_decoder: expected events are queued as
// stimulus is driven and matched against events captured from the outputs.
module tb_seg7_stream_decoder;

  localparam int S  = 4;
  localparam int EW = 8;

  typedef struct packed {
    logic [3:0]    digit;
    logic          dv;
    logic          inv;
    logic          serr;
    logic [EW-1:0] err;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    seg_n = 7'h7F;
  logic [3:0]    digit;
  logic          digit_valid;
  logic          blank;
  logic          invalid;
  logic          seq_err;
  logic [EW-1:0] err_cnt;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  exp_err  = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t mon_ev;
  ev_t o_ev;
  ev_t e_ev;
  logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  seg7_stream_decoder #(.STABLE_CYCLES(S), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .seg_n(seg_n), .digit(digit), .digit_valid(digit_valid),
    .blank(blank), .invalid(invalid), .seq_err(seq_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Capture every cycle that carries an event pulse.
  always @(negedge clk) begin
    if (digit_valid === 1'b1 || invalid === 1'b1 || seq_err === 1'b1) begin
      mon_ev = {digit, digit_valid, invalid, seq_err, err_cnt};
      obs_q.push_back(mon_ev);
    end
  end

  task automatic drive(input logic [6:0] p, input int n);
    repeat (n) begin
      seg_n = p;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic push_dig(input int d, input bit se);
    ev_t e;
    if (se && exp_err < 255) exp_err++;
    e = {4'(d), 1'b1, 1'b0, se, 8'(exp_err)};
    exp_q.push_back(e);
  endtask

  task automatic push_inv(input int held);
    ev_t e;
    if (exp_err < 255) exp_err++;
    e = {4'(held), 1'b0, 1'b1, 1'b0, 8'(exp_err)};
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    seg_n = 7'h7F;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (digit !== 4'd0) begin n_fail++; $display("FAIL reset_digit got %0d want 0", digit); end
    n_checks++; if (digit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv got %b want 0", digit_valid); end
    n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL reset_blank got %b want 1", blank); end
    n_checks++; if (invalid !== 1'b0) begin n_fail++; $display("FAIL reset_invalid got %b want 0", invalid); end
    n_checks++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL reset_seq_err got %b want 0", seq_err); end
    n_checks++; if (err_cnt !== '0) begin n_fail++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    rst = 1'b0;
    exp_err = 0;
    exp_q.delete();
    obs_q.delete();
    $display("reset: outputs checked");
  endtask

  task automatic test_count_up();
    for (int i = 0; i <= 10; i++) begin
      drive(tbl[i % 10], S);
      push_dig(i % 10, 1'b0);
    end
    settle();
    while (exp_q.size() > 0) begin
      e_ev = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL count_up missing event want %h", e_ev); end
      else begin
        o_ev = obs_q.pop_front();
        if (o_ev !== e_ev) begin n_fail++; $display("FAIL count_up event got %h want %h", o_ev, e_ev); end
        else $display("count_up: digit %0d ok", o_ev.digit);
      end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL count_up extra events got %0d want 0", obs_q.size()); end
    obs_q.delete();
    n_checks++; if (blank !== 1'b0) begin n_fail++; $display("FAIL count_up_blank got %b want 0", blank); end
  endtask

  task automatic test_glitch();
    drive(7'h7F, S);
    settle();
    n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL glitch_blank got %b want 1", blank); end
    drive(tbl[3], S - 1);
    drive(tbl[5], 6);
    push_dig(5, 1'b0);
    drive(tbl[0], S - 2);
    drive(tbl[5], S + 2);
    settle();
    while (exp_q.size() > 0) begin
      e_ev = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL glitch missing event want %h", e_ev); end
      else begin
        o_ev = obs_q.pop_front();
        if (o_ev !== e_ev) begin n_fail++; $display("FAIL glitch event got %h want %h", o_ev, e_ev); end
        else $display("glitch: digit %0d ok", o_ev.digit);
      end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL glitch extra events got %0d want 0", obs_q.size()); end
    obs_q.delete();
    n_checks++; if (digit !== 4'd5) begin n_fail++; $display("FAIL glitch_digit got %0d want 5", digit); end
  endtask

  task automatic test_seq_err();
    drive(7'h7F, S);
    drive(tbl[3], S);
    push_dig(3, 1'b0);
    drive(tbl[5], S);
    push_dig(5, 1'b1);
    settle();
    while (exp_q.size() > 0) begin
      e_ev = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL seq_err missing event want %h", e_ev); end
      else begin
        o_ev = obs_q.pop_front();
        if (o_ev !== e_ev) begin n_fail++; $display("FAIL seq_err event got %h want %h", o_ev, e_ev); end
        else $display("seq_err: digit %0d serr %b ok", o_ev.digit, o_ev.serr);
      end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL seq_err extra events got %0d want 0", obs_q.size()); end
    obs_q.delete();
    n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL seq_err_cnt got %0d want 1", err_cnt); end
  endtask

  task automatic test_invalid();
    drive(7'h55, S);
    push_inv(5);
    settle();
    n_checks++; if (digit !== 4'd5) begin n_fail++; $display("FAIL invalid_digit_held got %0d want 5", digit); end
    drive(tbl[4], S);
    push_dig(4, 1'b0);
    settle();
    while (exp_q.size() > 0) begin
      e_ev = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL invalid missing event want %h", e_ev); end
      else begin
        o_ev = obs_q.pop_front();
        if (o_ev !== e_ev) begin n_fail++; $display("FAIL invalid event got %h want %h", o_ev, e_ev); end
        else $display("invalid: event %h ok", o_ev);
      end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL invalid extra events got %0d want 0", obs_q.size()); end
    obs_q.delete();
    n_checks++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL invalid_err_cnt got %0d want 2", err_cnt); end
  endtask

  task automatic test_blank();
    drive(7'h7F, S);
    drive(tbl[9], S);
    push_dig(9, 1'b0);
    settle();
    n_checks++; if (blank !== 1'b0) begin n_fail++; $display("FAIL blank_after_9 got %b want 0", blank); end
    drive(7'h7F, S);
    settle();
    n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL blank_level got %b want 1", blank); end
    n_checks++; if (digit !== 4'd9) begin n_fail++; $display("FAIL blank_digit_held got %0d want 9", digit); end
    drive(tbl[9], 54);
    push_dig(9, 1'b0);
    settle();
    n_checks++; if (blank !== 1'b0) begin n_fail++; $display("FAIL blank_cleared got %b want 0", blank); end
    while (exp_q.size() > 0) begin
      e_ev = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL blank missing event want %h", e_ev); end
      else begin
        o_ev = obs_q.pop_front();
        if (o_ev !== e_ev) begin n_fail++; $display("FAIL blank event got %h want %h", o_ev, e_ev); end
        else $display("blank: digit %0d ok", o_ev.digit);
      end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL blank extra events got %0d want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_saturate_and_reset();
    // Alternating 2 and 0 never follows the +1 rule, so every accept is a seq error.
    for (int i = 0; i < 260; i++) begin
      drive(tbl[(i % 2 == 0) ? 2 : 0], S);
      push_dig((i % 2 == 0) ? 2 : 0, 1'b1);
    end
    settle();
    while (exp_q.size() > 0) begin
      e_ev = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL saturate missing event want %h", e_ev); end
      else begin
        o_ev = obs_q.pop_front();
        if (o_ev !== e_ev) begin n_fail++; $display("FAIL saturate event got %h want %h", o_ev, e_ev); end
        else $display("saturate: digit %0d err_cnt %0d ok", o_ev.digit, o_ev.err);
      end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL saturate extra events got %0d want 0", obs_q.size()); end
    obs_q.delete();
    n_checks++; if (err_cnt !== 8'hFF) begin n_fail++; $display("FAIL saturate_err_cnt got %0d want 255", err_cnt); end
    drive(tbl[7], 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (digit !== 4'd0) begin n_fail++; $display("FAIL midrst_digit got %0d want 0", digit); end
    n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL midrst_blank got %b want 1", blank); end
    n_checks++; if (err_cnt !== '0) begin n_fail++; $display("FAIL midrst_err_cnt got %0d want 0", err_cnt); end
    n_checks++; if ({digit_valid, invalid, seq_err} !== 3'b000) begin n_fail++; $display("FAIL midrst_pulses got %b want 000", {digit_valid, invalid, seq_err}); end
    rst = 1'b0;
    exp_err = 0;
    obs_q.delete();
    drive(tbl[7], S);
    push_dig(7, 1'b0);
    settle();
    while (exp_q.size() > 0) begin
      e_ev = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL post_rst missing event want %h", e_ev); end
      else begin
        o_ev = obs_q.pop_front();
        if (o_ev !== e_ev) begin n_fail++; $display("FAIL post_rst event got %h want %h", o_ev, e_ev); end
        else $display("post_rst: digit %0d ok", o_ev.digit);
      end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL post_rst extra events got %0d want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_glitch();
    test_seq_err();
    test_invalid();
    test_blank();
    test_saturate_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
